// File: rtl/instr_reader.sv
// Read/execute side of the instruction register: walks read_pointer over a block,
// executes each instruction and streams results on a valid/ready port.
// Optional build macro INSTR_READER_STATS_EN adds saturating exec_cnt/err_cnt outputs.
module instr_reader #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 4,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          start_addr,
    input  logic [ADDR_W:0]            count,
    output logic [ADDR_W-1:0]          read_pointer,
    input  logic [OP_W+2*DATA_W-1:0]   instruction_word,
    output logic                       busy,
    output logic                       done,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [2*DATA_W-1:0]        res_data,
    output logic [ADDR_W-1:0]          res_addr,
    output logic                       res_err
`ifdef INSTR_READER_STATS_EN
    ,
    output logic [15:0]                exec_cnt,
    output logic [15:0]                err_cnt
`endif
);

    localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, OUT, FINISH} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_W-1:0]     read_pointer_reg, read_pointer_next;
    logic [ADDR_W:0]       remaining_reg, remaining_next;
    logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic                  busy_reg, busy_next;
    logic [2*DATA_W-1:0]   res_data_reg, res_data_next;
    logic                  res_err_reg, res_err_next;

    logic [OP_W-1:0]            opcode;
    logic signed [2*DATA_W-1:0] a_ext, b_ext;
    logic [2*DATA_W-1:0]        exec_data;
    logic                       exec_err;
    logic                       transfer;

    assign opcode   = instruction_word[OP_W+2*DATA_W-1 -: OP_W];
    assign a_ext    = {{DATA_W{instruction_word[2*DATA_W-1]}}, instruction_word[2*DATA_W-1 -: DATA_W]};
    assign b_ext    = {{DATA_W{instruction_word[DATA_W-1]}}, instruction_word[DATA_W-1:0]};
    assign transfer = (state_reg == OUT) && res_ready;

    // Operands are widened first so the product is exact and no op overflows.
    always_comb begin
        exec_data = '0;
        exec_err  = 1'b0;
        case (opcode)
            OP_W'(0): exec_data = '0;
            OP_W'(1): exec_data = a_ext;
            OP_W'(2): exec_data = b_ext;
            OP_W'(3): exec_data = a_ext + b_ext;
            OP_W'(4): exec_data = a_ext - b_ext;
            OP_W'(5): exec_data = a_ext * b_ext;
            OP_W'(6): begin
                if (b_ext == '0) exec_err = 1'b1;
                else             exec_data = a_ext / b_ext;
            end
            OP_W'(7): begin
                if (b_ext == '0) exec_err = 1'b1;
                else             exec_data = a_ext % b_ext;
            end
            default:  exec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next        = state_reg;
        read_pointer_next = read_pointer_reg;
        remaining_next    = remaining_reg;
        wait_cnt_next     = wait_cnt_reg;
        busy_next         = busy_reg;
        res_data_next     = res_data_reg;
        res_err_next      = res_err_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    read_pointer_next = start_addr;
                    remaining_next    = count;
                    busy_next         = 1'b1;
                    state_next        = (count == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                wait_cnt_next = '0;
                state_next    = (RD_LAT > 1) ? WAIT : EXEC;
            end
            WAIT: begin
                if (wait_cnt_reg == WAIT_W'(RD_LAT - 2)) state_next = EXEC;
                else                                     wait_cnt_next = wait_cnt_reg + 1'b1;
            end
            EXEC: begin
                res_data_next = exec_data;
                res_err_next  = exec_err;
                state_next    = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    read_pointer_next = read_pointer_reg + 1'b1;
                    remaining_next    = remaining_reg - 1'b1;
                    state_next        = (remaining_reg == (ADDR_W+1)'(1)) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            read_pointer_reg <= '0;
            remaining_reg    <= '0;
            wait_cnt_reg     <= '0;
            busy_reg         <= 1'b0;
            res_data_reg     <= '0;
            res_err_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            read_pointer_reg <= read_pointer_next;
            remaining_reg    <= remaining_next;
            wait_cnt_reg     <= wait_cnt_next;
            busy_reg         <= busy_next;
            res_data_reg     <= res_data_next;
            res_err_reg      <= res_err_next;
        end
    end

    // The result address is the pointer, which only advances on transfer.
    assign read_pointer = read_pointer_reg;
    assign busy         = busy_reg;
    assign done         = (state_reg == FINISH);
    assign res_valid    = (state_reg == OUT);
    assign res_data     = res_data_reg;
    assign res_addr     = read_pointer_reg;
    assign res_err      = res_err_reg;

`ifdef INSTR_READER_STATS_EN
    logic [15:0] exec_cnt_reg, err_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_cnt_reg <= '0;
            err_cnt_reg  <= '0;
        end else if (transfer) begin
            if (exec_cnt_reg != 16'hFFFF)             exec_cnt_reg <= exec_cnt_reg + 1'b1;
            if (res_err_reg && err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign exec_cnt = exec_cnt_reg;
    assign err_cnt  = err_cnt_reg;
`else
    logic unused_transfer;
    assign unused_transfer = transfer;
`endif

endmodule

// File: tb/tb_instr_reader.sv
// Directed bench for instr_reader: registered-read instruction memory model,
// transfer monitor, and immediate-assertion checks on each expected value.
module tb_instr_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  start_addr;
    logic [5:0]  count;
    logic [4:0]  read_pointer;
    logic [67:0] instruction_word;
    logic        busy, done, res_valid, res_ready, res_err;
    logic [63:0] res_data;
    logic [4:0]  res_addr;
`ifdef INSTR_READER_STATS_EN
    logic [15:0] exec_cnt, err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [67:0] mem [0:31];

    logic [4:0]  tq_addr [$];
    logic [63:0] tq_data [$];
    logic        tq_err  [$];
    int          tq_cyc  [$];
    int          cyc = 0;
    int          valid_cycles = 0;
    int          done_cnt = 0;

    instr_reader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .busy             (busy),
        .done             (done),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_addr         (res_addr),
        .res_err          (res_err)
`ifdef INSTR_READER_STATS_EN
        ,
        .exec_cnt         (exec_cnt),
        .err_cnt          (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) instruction_word <= mem[read_pointer];

    // Inputs change just after posedge, so negedge sees the values the next edge uses.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (res_valid) valid_cycles <= valid_cycles + 1;
        if (done)      done_cnt <= done_cnt + 1;
        if (res_valid && res_ready) begin
            tq_addr.push_back(res_addr);
            tq_data.push_back(res_data);
            tq_err.push_back(res_err);
            tq_cyc.push_back(cyc);
        end
    end

    function automatic logic [67:0] mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return {op, a, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [4:0] a, input logic [5:0] c);
        start      = 1'b1;
        start_addr = a;
        count      = c;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 1;
        while (res_valid !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        check("valid_seen", 64'(res_valid), 64'd1);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (done !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        tick();
        check("done_pulse_one_cycle", 64'(done), 64'd0);
        check("busy_clear", 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int qb;
        int db;
        int vb;

        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[3]  = mk(4'd3, 32'd5, -32'sd7);
        mem[30] = mk(4'd4, 32'd10, 32'd25);
        mem[31] = mk(4'd2, 32'd0, -32'sd3);
        mem[0]  = mk(4'd0, 32'd123, 32'd456);
        mem[1]  = mk(4'd7, -32'sd20, 32'd3);
        mem[10] = mk(4'd6, 32'd9, 32'd0);
        mem[11] = mk(4'd7, 32'd9, 32'd0);
        mem[12] = mk(4'd9, 32'd9, 32'd4);
        mem[5]  = mk(4'd5, 32'h7FFFFFFF, 32'h7FFFFFFF);
        mem[20] = mk(4'd6, -32'sd20, 32'd3);
        mem[21] = mk(4'd1, -32'sd1, 32'd0);

        reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; res_ready = 1'b1;
        repeat (3) tick();
        check("rst_read_pointer", 64'(read_pointer), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", res_data, 64'd0);
        check("rst_res_err", 64'(res_err), 64'd0);
        reset = 1'b0;
        tick();

        // ADD 5 + -7 at address 3
        qb = tq_addr.size();
        pulse_start(5'd3, 6'd1);
        check("add_busy", 64'(busy), 64'd1);
        wait_valid(20, lat);
        check("add_latency", 64'(lat), 64'd3);
        check("add_data", res_data, -64'sd2);
        check("add_addr", 64'(res_addr), 64'd3);
        check("add_err", 64'(res_err), 64'd0);
        tick();
        check("add_done_after_xfer", 64'(done), 64'd1);
        check("add_valid_dropped", 64'(res_valid), 64'd0);
        tick();
        check("add_done_low", 64'(done), 64'd0);
        check("add_busy_low", 64'(busy), 64'd0);
        check("add_xfers", 64'(tq_addr.size() - qb), 64'd1);

        // Wrapping sequence 30,31,0,1
        qb = tq_addr.size();
        pulse_start(5'd30, 6'd4);
        wait_done(60);
        check("wrap_xfers", 64'(tq_addr.size() - qb), 64'd4);
        if (tq_addr.size() - qb == 4) begin
            check("wrap_addr0", 64'(tq_addr[qb]),   64'd30);
            check("wrap_addr1", 64'(tq_addr[qb+1]), 64'd31);
            check("wrap_addr2", 64'(tq_addr[qb+2]), 64'd0);
            check("wrap_addr3", 64'(tq_addr[qb+3]), 64'd1);
            check("sub_data",   tq_data[qb],   -64'sd15);
            check("passb_data", tq_data[qb+1], -64'sd3);
            check("zero_data",  tq_data[qb+2], 64'd0);
            check("mod_data",   tq_data[qb+3], -64'sd2);
            check("throughput", 64'(tq_cyc[qb+1] - tq_cyc[qb]), 64'd3);
        end

        // Division/modulo by zero and illegal opcode
        qb = tq_addr.size();
        pulse_start(5'd10, 6'd3);
        wait_done(60);
        check("err_xfers", 64'(tq_addr.size() - qb), 64'd3);
        if (tq_addr.size() - qb == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("err_data", tq_data[qb+i], 64'd0);
                check("err_flag", 64'(tq_err[qb+i]), 64'd1);
            end
        end
`ifdef INSTR_READER_STATS_EN
        check("stats_err_cnt", 64'(err_cnt), 64'd3);
        check("stats_exec_cnt", 64'(exec_cnt), 64'd8);
`endif

        // Full-width multiply held under backpressure
        qb = tq_addr.size();
        res_ready = 1'b0;
        pulse_start(5'd5, 6'd1);
        wait_valid(20, lat);
        for (int i = 0; i < 5; i++) begin
            check("mult_hold_data", res_data, 64'h3FFFFFFF00000001);
            check("mult_hold_valid", 64'(res_valid), 64'd1);
            tick();
        end
        check("mult_no_xfer_yet", 64'(tq_addr.size() - qb), 64'd0);
        res_ready = 1'b1;
        wait_done(20);
        check("mult_xfers", 64'(tq_addr.size() - qb), 64'd1);

        // count = 0
        vb = valid_cycles;
        pulse_start(5'd7, 6'd0);
        check("cnt0_done", 64'(done), 64'd1);
        check("cnt0_busy", 64'(busy), 64'd1);
        tick();
        check("cnt0_done_low", 64'(done), 64'd0);
        check("cnt0_busy_low", 64'(busy), 64'd0);
        check("cnt0_no_valid", 64'(valid_cycles - vb), 64'd0);

        // start while busy is ignored
        qb = tq_addr.size();
        pulse_start(5'd20, 6'd2);
        tick();
        pulse_start(5'd0, 6'd5);
        wait_done(60);
        check("busy_start_xfers", 64'(tq_addr.size() - qb), 64'd2);
        if (tq_addr.size() - qb == 2) begin
            check("busy_addr0", 64'(tq_addr[qb]),   64'd20);
            check("busy_addr1", 64'(tq_addr[qb+1]), 64'd21);
            check("div_data",   tq_data[qb],   -64'sd6);
            check("passa_data", tq_data[qb+1], -64'sd1);
        end

        // Reset while a result is waiting
        res_ready = 1'b0;
        pulse_start(5'd3, 6'd1);
        wait_valid(20, lat);
        db = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("rstmid_valid", 64'(res_valid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_data", res_data, 64'd0);
        check("rstmid_ptr", 64'(read_pointer), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("rstmid_no_done", 64'(done_cnt - db), 64'd0);
        check("rstmid_idle_valid", 64'(res_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
